// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: zero-wait round-robin grant with a bounded lock,
// plus an owner-tag pipeline that returns read-valid to the master that issued the read.
module mem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_LOCK     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [2:0]  m0_funct3,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [2:0]  m1_funct3,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_wen,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_ra,
  output logic [31:0] mem_wa,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [7:0] LP_MAX_LOCK = 8'(MAX_LOCK);

  typedef enum logic {LK_FREE, LK_HELD} lock_state_e;

  lock_state_e r_lk_state, w_lk_state_nxt;
  logic        r_lk_owner, w_lk_owner_nxt;
  logic [7:0]  r_lk_cnt, w_lk_cnt_nxt;
  logic        r_last, w_last_nxt;

  // Bit i of the tag pipeline is a read accepted i+1 cycles ago; the MSB fires rvalid.
  logic [READ_LATENCY-1:0] r_tag_vld, r_tag_own;
  logic [READ_LATENCY:0]   w_vld_chain, w_own_chain;

  logic w_owner_req, w_lock_hold;
  logic w_gnt0, w_gnt1, w_any_gnt, w_sel, w_sel_we, w_sel_lock, w_rd_acc;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_owner_req = r_lk_owner ? m1_req : m0_req;
    w_lock_hold = (r_lk_state == LK_HELD) && w_owner_req && (r_lk_cnt < LP_MAX_LOCK);
    if (!rst) begin
      if (w_lock_hold) begin
        w_gnt0 = ~r_lk_owner;
        w_gnt1 = r_lk_owner;
      end else if (m0_req && m1_req) begin
        w_gnt0 = r_last;
        w_gnt1 = ~r_last;
      end else begin
        w_gnt0 = m0_req;
        w_gnt1 = m1_req;
      end
    end
  end

  assign w_any_gnt  = w_gnt0 | w_gnt1;
  assign w_sel      = w_gnt1;
  assign w_sel_we   = w_gnt1 ? m1_we   : m0_we;
  assign w_sel_lock = w_gnt1 ? m1_lock : m0_lock;
  assign w_rd_acc   = w_any_gnt & ~w_sel_we;

  always_comb begin
    w_lk_state_nxt = r_lk_state;
    w_lk_owner_nxt = r_lk_owner;
    w_lk_cnt_nxt   = r_lk_cnt;
    w_last_nxt     = r_last;
    if (w_any_gnt) begin
      w_last_nxt = w_sel;
      if (w_sel_lock) begin
        // A grant won by arbitration (not by holding) starts a fresh locked run.
        w_lk_state_nxt = LK_HELD;
        w_lk_owner_nxt = w_sel;
        w_lk_cnt_nxt   = w_lock_hold ? r_lk_cnt + 8'd1 : 8'd1;
      end else begin
        w_lk_state_nxt = LK_FREE;
        w_lk_cnt_nxt   = 8'd0;
      end
    end else begin
      w_lk_state_nxt = LK_FREE;
      w_lk_cnt_nxt   = 8'd0;
    end
  end

  assign w_vld_chain = {r_tag_vld, w_rd_acc};
  assign w_own_chain = {r_tag_own, w_sel};

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lk_state <= LK_FREE;
      r_lk_owner <= 1'b0;
      r_lk_cnt   <= 8'd0;
      r_last     <= 1'b1;
      // NOTE: the tag pipeline is reset deliberately; a stale valid bit would fire rvalid after reset.
      r_tag_vld  <= '0;
      r_tag_own  <= '0;
    end else begin
      r_lk_state <= w_lk_state_nxt;
      r_lk_owner <= w_lk_owner_nxt;
      r_lk_cnt   <= w_lk_cnt_nxt;
      r_last     <= w_last_nxt;
      r_tag_vld  <= w_vld_chain[READ_LATENCY-1:0];
      r_tag_own  <= w_own_chain[READ_LATENCY-1:0];
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = !rst && r_tag_vld[READ_LATENCY-1] && !r_tag_own[READ_LATENCY-1];
  assign m1_rvalid = !rst && r_tag_vld[READ_LATENCY-1] &&  r_tag_own[READ_LATENCY-1];
  assign m0_rdata  = mem_rd;
  assign m1_rdata  = mem_rd;

  assign mem_wen    = w_any_gnt & w_sel_we;
  assign mem_funct3 = w_gnt1 ? m1_funct3 : (w_gnt0 ? m0_funct3 : 3'd0);
  assign mem_ra     = w_gnt1 ? m1_addr   : (w_gnt0 ? m0_addr   : 32'd0);
  assign mem_wa     = mem_ra;
  assign mem_wd     = w_gnt1 ? m1_wdata  : (w_gnt0 ? m0_wdata  : 32'd0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 1 / lock 3, latency 2 / lock 8) share
// stimulus; directed scenarios plus a randomized run against a behavioural model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [2:0]  m0_funct3, m1_funct3;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rd;

  logic        m0_gnt [2];
  logic        m1_gnt [2];
  logic        m0_rvalid [2];
  logic        m1_rvalid [2];
  logic [31:0] m0_rdata [2];
  logic [31:0] m1_rdata [2];
  logic        mem_wen [2];
  logic [2:0]  mem_funct3 [2];
  logic [31:0] mem_ra [2];
  logic [31:0] mem_wa [2];
  logic [31:0] mem_wd [2];

  int vectors     = 0;
  int miscompares = 0;
  int rl [2] = '{1, 2};
  int ml [2] = '{3, 8};

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_arbiter #(
      .READ_LATENCY(k == 0 ? 1 : 2),
      .MAX_LOCK    (k == 0 ? 3 : 8)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_lock   (m0_lock),
      .m0_funct3 (m0_funct3),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_lock   (m1_lock),
      .m1_funct3 (m1_funct3),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m0_gnt    (m0_gnt[k]),
      .m0_rvalid (m0_rvalid[k]),
      .m0_rdata  (m0_rdata[k]),
      .m1_gnt    (m1_gnt[k]),
      .m1_rvalid (m1_rvalid[k]),
      .m1_rdata  (m1_rdata[k]),
      .mem_wen   (mem_wen[k]),
      .mem_funct3(mem_funct3[k]),
      .mem_ra    (mem_ra[k]),
      .mem_wa    (mem_wa[k]),
      .mem_wd    (mem_wd[k]),
      .mem_rd    (mem_rd)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_funct3 = 3'($urandom);
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_funct3 = 3'($urandom);
    m0_addr = $urandom(); m0_wdata = $urandom();
    m1_addr = $urandom(); m1_wdata = $urandom();
    mem_rd  = $urandom();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_wen[k]} !== 5'b0) begin
          miscompares++;
          $display("FAIL reset_ctrl inst%0d c%0d: got %b want 00000", k, c,
                   {m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_wen[k]});
        end
        vectors++;
        if ({mem_funct3[k], mem_ra[k], mem_wa[k], mem_wd[k]} !== 99'd0) begin
          miscompares++;
          $display("FAIL reset_bus inst%0d c%0d: got %h want 0", k, c,
                   {mem_funct3[k], mem_ra[k], mem_wa[k], mem_wd[k]});
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_rr_reads();
    bit e0, e1, er0, er1;
    int src;
    logic [31:0] era;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      m0_req = (c < 4); m1_req = (c < 4); m0_we = 1'b0; m1_we = 1'b0;
      m0_addr = 32'h1000 + 32'(c); m1_addr = 32'h2000 + 32'(c);
      mem_rd = $urandom();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e0  = (c < 4) && (c % 2 == 0);
        e1  = (c < 4) && (c % 2 == 1);
        era = e0 ? m0_addr : (e1 ? m1_addr : 32'd0);
        src = c - rl[k];
        er0 = (src >= 0) && (src < 4) && (src % 2 == 0);
        er1 = (src >= 0) && (src < 4) && (src % 2 == 1);
        vectors++;
        if ({m0_gnt[k], m1_gnt[k]} !== {e0, e1}) begin
          miscompares++;
          $display("FAIL rr_gnt inst%0d c%0d: got %b want %b", k, c, {m0_gnt[k], m1_gnt[k]}, {e0, e1});
        end
        vectors++;
        if (mem_ra[k] !== era) begin
          miscompares++;
          $display("FAIL rr_addr inst%0d c%0d: got %h want %h", k, c, mem_ra[k], era);
        end
        vectors++;
        if ({m0_rvalid[k], m1_rvalid[k]} !== {er0, er1}) begin
          miscompares++;
          $display("FAIL rr_rvalid inst%0d c%0d: got %b want %b", k, c, {m0_rvalid[k], m1_rvalid[k]}, {er0, er1});
        end
        vectors++;
        if ({m0_rdata[k], m1_rdata[k]} !== {mem_rd, mem_rd}) begin
          miscompares++;
          $display("FAIL rr_rdata inst%0d c%0d: got %h want %h", k, c, {m0_rdata[k], m1_rdata[k]}, {mem_rd, mem_rd});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write();
    logic [102:0] exp_v;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      m1_req = (c == 0); m1_we = 1'b1; m1_lock = 1'b0; m1_funct3 = 3'b010;
      m1_addr = 32'h100; m1_wdata = 32'hDEADBEEF;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        exp_v = (c == 0) ? {1'b0, 1'b1, 1'b1, 3'b010, 32'h100, 32'h100, 32'hDEADBEEF} : 103'd0;
        vectors++;
        if ({m0_gnt[k], m1_gnt[k], mem_wen[k], mem_funct3[k], mem_ra[k], mem_wa[k], mem_wd[k]} !== exp_v) begin
          miscompares++;
          $display("FAIL write_bus inst%0d c%0d: got %h want %h", k, c,
                   {m0_gnt[k], m1_gnt[k], mem_wen[k], mem_funct3[k], mem_ra[k], mem_wa[k], mem_wd[k]}, exp_v);
        end
        vectors++;
        if ({m0_rvalid[k], m1_rvalid[k]} !== 2'b00) begin
          miscompares++;
          $display("FAIL write_rvalid inst%0d c%0d: got %b want 00", k, c, {m0_rvalid[k], m1_rvalid[k]});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock();
    bit e1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      m0_req  = 1'b1;
      m1_req  = (c >= 1) && (c <= 8);
      m1_lock = 1'b1; m0_lock = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (c == 0 || c == 9) e1 = 1'b0;
        else if (k == 0)      e1 = ((c - 1) % 4 != 3);
        else                  e1 = 1'b1;
        vectors++;
        if ({m0_gnt[k], m1_gnt[k]} !== {~e1, e1}) begin
          miscompares++;
          $display("FAIL lock_gnt inst%0d c%0d: got %b want %b", k, c, {m0_gnt[k], m1_gnt[k]}, {~e1, e1});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_latency2();
    bit er0, er1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      m0_req = (c == 0); m1_req = (c == 1); m0_we = 1'b0; m1_we = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        er0 = (c == rl[k]);
        er1 = (c == 1 + rl[k]);
        vectors++;
        if ({m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k]} !== {c == 0, c == 1, er0, er1}) begin
          miscompares++;
          $display("FAIL lat_rvalid inst%0d c%0d: got %b want %b", k, c,
                   {m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k]}, {c == 0, c == 1, er0, er1});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      rst    = (c >= 1) && (c <= 3);
      m0_req = (c <= 3); m1_req = (c >= 1) && (c <= 3);
      m0_we  = 1'b0; m1_we = (c == 2);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_wen[k]} !== {c == 0, 4'b0}) begin
          miscompares++;
          $display("FAIL midrst_ctrl inst%0d c%0d: got %b want %b", k, c,
                   {m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_wen[k]}, {c == 0, 4'b0});
        end
        if (c >= 1 && c <= 3) begin
          vectors++;
          if ({mem_funct3[k], mem_ra[k], mem_wa[k], mem_wd[k]} !== 99'd0) begin
            miscompares++;
            $display("FAIL midrst_bus inst%0d c%0d: got %h want 0", k, c,
                     {mem_funct3[k], mem_ra[k], mem_wa[k], mem_wd[k]});
          end
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      m0_req = (c == 0) || (c == 6);
      m1_req = (c == 6);
      m0_we  = $urandom_range(0, 1) == 1;
      m1_we  = $urandom_range(0, 1) == 1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({m0_gnt[k], m1_gnt[k]} !== {c == 0, c == 6}) begin
          miscompares++;
          $display("FAIL idle_gnt inst%0d c%0d: got %b want %b", k, c, {m0_gnt[k], m1_gnt[k]}, {c == 0, c == 6});
        end
        if (c >= 1 && c <= 5) begin
          vectors++;
          if ({mem_wen[k], mem_funct3[k], mem_ra[k], mem_wa[k], mem_wd[k]} !== 100'd0) begin
            miscompares++;
            $display("FAIL idle_bus inst%0d c%0d: got %h want 0", k, c,
                     {mem_wen[k], mem_funct3[k], mem_ra[k], mem_wa[k], mem_wd[k]});
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int last [2];
    int owner [2];
    int run [2];
    int sched [2][16];
    logic rq [2];
    logic we [2];
    logic lk [2];
    logic [2:0]  f3 [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    int w;
    bit held, ev0, ev1, ewen;
    logic [98:0] ebus;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      last[k] = 1; owner[k] = -1; run[k] = 0;
      for (int s = 0; s < 16; s++) sched[k][s] = -1;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 49) == 0);
      m0_req = ($urandom_range(0, 9) < 7); m1_req = ($urandom_range(0, 9) < 7);
      m0_we  = ($urandom_range(0, 3) == 0); m1_we = ($urandom_range(0, 3) == 0);
      m0_lock = ($urandom_range(0, 3) != 0); m1_lock = ($urandom_range(0, 3) != 0);
      m0_funct3 = 3'($urandom); m1_funct3 = 3'($urandom);
      m0_addr = $urandom(); m1_addr = $urandom();
      m0_wdata = $urandom(); m1_wdata = $urandom();
      mem_rd = $urandom();
      rq[0] = m0_req; rq[1] = m1_req; we[0] = m0_we; we[1] = m1_we;
      lk[0] = m0_lock; lk[1] = m1_lock; f3[0] = m0_funct3; f3[1] = m1_funct3;
      ad[0] = m0_addr; ad[1] = m1_addr; wd[0] = m0_wdata; wd[1] = m1_wdata;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        w = -1; held = 1'b0;
        if (!rst) begin
          if (owner[k] >= 0 && rq[owner[k]] && run[k] < ml[k]) begin
            w = owner[k]; held = 1'b1;
          end else if (rq[0] && rq[1]) w = 1 - last[k];
          else if (rq[0]) w = 0;
          else if (rq[1]) w = 1;
        end
        ev0  = !rst && (sched[k][cyc % 16] == 0);
        ev1  = !rst && (sched[k][cyc % 16] == 1);
        ewen = (w >= 0) ? we[w] : 1'b0;
        ebus = (w >= 0) ? {f3[w], ad[w], ad[w], wd[w]} : 99'd0;
        vectors++;
        if ({m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_wen[k]} !== {w == 0, w == 1, ev0, ev1, ewen}) begin
          miscompares++;
          $display("FAIL rand_ctrl inst%0d cyc%0d: got %b want %b", k, cyc,
                   {m0_gnt[k], m1_gnt[k], m0_rvalid[k], m1_rvalid[k], mem_wen[k]}, {w == 0, w == 1, ev0, ev1, ewen});
        end
        vectors++;
        if ({mem_funct3[k], mem_ra[k], mem_wa[k], mem_wd[k]} !== ebus) begin
          miscompares++;
          $display("FAIL rand_bus inst%0d cyc%0d: got %h want %h", k, cyc,
                   {mem_funct3[k], mem_ra[k], mem_wa[k], mem_wd[k]}, ebus);
        end
        vectors++;
        if ({m0_rdata[k], m1_rdata[k]} !== {mem_rd, mem_rd}) begin
          miscompares++;
          $display("FAIL rand_rdata inst%0d cyc%0d: got %h want %h", k, cyc, {m0_rdata[k], m1_rdata[k]}, {mem_rd, mem_rd});
        end
        sched[k][cyc % 16] = -1;
        if (rst) begin
          last[k] = 1; owner[k] = -1; run[k] = 0;
          for (int s = 0; s < 16; s++) sched[k][s] = -1;
        end else if (w >= 0) begin
          if (lk[w]) begin
            run[k]   = held ? run[k] + 1 : 1;
            owner[k] = w;
          end else begin
            owner[k] = -1; run[k] = 0;
          end
          last[k] = w;
          if (!we[w]) sched[k][(cyc + rl[k]) % 16] = w;
        end else begin
          owner[k] = -1; run[k] = 0;
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_rr_reads();
    test_write();
    test_lock();
    test_latency2();
    test_reset_midop();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, the memory read-data latency in clock cycles (legal range 1..4).
REQ-002 SHALL have parameter MAX_LOCK, default 8, the maximum number of consecutive locked transfers one master may hold (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have ports m0_req, m1_req, input, 1 bit each, transfer request from master 0 (CPU) and master 1 (DMA/loader).
REQ-006 SHALL have ports mX_we, input, 1 bit; mX_lock, input, 1 bit; mX_funct3, input, 3 bits; mX_addr, input, 32 bits; mX_wdata, input, 32 bits; one set per master X in {0,1}.
REQ-007 SHALL have ports mX_gnt, output, 1 bit, transfer accepted this cycle; mX_rvalid, output, 1 bit, read data valid; mX_rdata, output, 32 bits; one set per master.
REQ-008 SHALL have memory-side ports mem_wen, output, 1 bit; mem_funct3, output, 3 bits; mem_ra, output, 32 bits; mem_wa, output, 32 bits; mem_wd, output, 32 bits; mem_rd, input, 32 bits.

Function
REQ-009 SHALL grant at most one master per cycle; a transfer is accepted in the cycle where mX_req and mX_gnt are both high.
REQ-010 SHALL compute mX_gnt combinationally from current requests and registered arbiter state (zero-wait acceptance).
REQ-011 SHALL, with no lock active and both masters requesting, grant the master not granted by the most recent accepted transfer (round-robin pointer); with one requester, grant it.
REQ-012 SHALL update the round-robin pointer only on accepted transfers.
REQ-013 SHALL drive mem_funct3, mem_ra, mem_wa (both = granted mX_addr) and mem_wd from the granted master; mem_wen = granted mX_we.
REQ-014 SHALL drive mem_wen = 0 and mem_ra, mem_wa, mem_wd, mem_funct3 = 0 in any cycle with no grant.
REQ-015 SHALL, for each accepted read (mX_we = 0), assert mX_rvalid for exactly one cycle READ_LATENCY cycles after acceptance, using a READ_LATENCY-deep owner-tag pipeline.
REQ-016 SHALL drive mX_rdata = mem_rd continuously; only mX_rvalid qualifies it.
REQ-017 SHALL support one accepted read per cycle back-to-back, alternating masters, without lost or misrouted rvalid.
REQ-018 SHALL, when an accepted transfer has mX_lock = 1, keep grant with master X on following cycles while mX_req stays high, even if the other master requests.
REQ-019 SHALL count consecutive locked transfers; after MAX_LOCK of them, SHALL ignore lock for one arbitration and apply round-robin, then restart the count at 0.
REQ-020 SHALL release the lock immediately when the locking master deasserts req or accepts a transfer with mX_lock = 0; the count then resets to 0.
REQ-021 SHALL not grant the other master while a lock is active, even if the locking master idles for zero cycles between transfers.
REQ-022 SHALL never assert both m0_gnt and m1_gnt, nor mX_gnt without mX_req.

Reset
REQ-023 SHALL, while rst is high, force m0_gnt = m1_gnt = 0, mem_wen = 0, all mem_* address/data outputs = 0, and m0_rvalid = m1_rvalid = 0.
REQ-024 SHALL, on reset, clear the owner-tag pipeline, lock state and lock count, and set the pointer so master 0 wins the first contended cycle.
REQ-025 SHALL, for reset asserted mid-operation, discard in-flight reads: no rvalid in any cycle after rst rises, including reads accepted before it.

Verification
REQ-026 Bench SHALL check: after reset, m0_req = m1_req = 1 (reads) for 4 cycles -> grants 0,1,0,1; rvalid 0,1,0,1 one cycle later each.
REQ-027 Bench SHALL check: m1 write addr 0x100, wdata 0xDEADBEEF, funct3 3'b010 alone -> m1_gnt = 1, mem_wen = 1, mem_wa = 0x100, mem_wd = 0xDEADBEEF same cycle; no rvalid.
REQ-028 Bench SHALL check: MAX_LOCK = 3, m1 locked continuous requests, m0 requesting -> m1 granted 3 cycles, m0 granted 4th cycle, count restarts.
REQ-029 Bench SHALL check: READ_LATENCY = 2, m0 read at cycle 0, m1 read at cycle 1 -> m0_rvalid at cycle 2, m1_rvalid at cycle 3, each single-cycle.
REQ-030 Bench SHALL check: m0 read accepted, rst high next cycle -> m0_rvalid never asserts; all outputs 0 during rst.
REQ-031 Bench SHALL check: no requests for 5 cycles -> mem_wen = 0, mem_* outputs 0, no grants, pointer unchanged.
